// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int XZR        = 31;
    localparam int WAIT_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the load in EX writes a register the ID instruction reads.
module load_use_detect #(
    parameter int REG_IDX_W = pipe_ctrl_pkg::REG_IDX_W
) (
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs2,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 load_use
);
    import pipe_ctrl_pkg::*;

    logic rd_is_xzr;
    logic rs1_hit;
    logic rs2_hit;

    // XZR reads as zero, so a load targeting it never creates a dependency.
    assign rd_is_xzr = (ex_rd == REG_IDX_W'(XZR));
    assign rs1_hit   = (ex_rd == id_rs1);
    assign rs2_hit   = id_uses_rs2 && (ex_rd == id_rs2);
    assign load_use  = ex_mem_read && !rd_is_xzr && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline controller: load-use stall, MEM branch flush, dmem freeze and timeout.
// Optional PIPE_PERF_EN adds stall_count / flush_count performance counters.
module pipe_hazard_ctrl #(
    parameter int WAIT_LIMIT = 255,
    parameter int REG_IDX_W  = pipe_ctrl_pkg::REG_IDX_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs2,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 mem_branch,
    input  logic                 mem_uncond,
    input  logic                 mem_zero,
    input  logic                 mem_access,
    input  logic                 dmem_ready,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic                 exmem_flush,
    output logic                 pipe_freeze,
    output logic                 mem_timeout
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0]          stall_count,
    output logic [31:0]          flush_count
`endif
);
    import pipe_ctrl_pkg::*;

    pipe_state_t           state_reg, state_next;
    logic [WAIT_CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic                  timeout_reg, timeout_next;

    logic stall_mem;
    logic taken;
    logic load_use;

    assign stall_mem = mem_access && !dmem_ready;
    assign taken     = mem_branch && (mem_uncond || mem_zero);

    load_use_detect #(
        .REG_IDX_W (REG_IDX_W)
    ) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    // The counter stops at WAIT_LIMIT, so it can never wrap.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        case (state_reg)
            RUN: begin
                if (stall_mem) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_CNT_W'(WAIT_LIMIT)) begin
                    state_next    = HALT;
                    timeout_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_CNT_W'(1);
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // A taken branch squashes the hazarding instruction, so it outranks load-use.
    always_comb begin
        pipe_freeze = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        if (reset || state_reg == HALT || stall_mem) begin
            pipe_freeze = 1'b1;
        end else if (taken) begin
            pc_src      = 1'b1;
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            idex_bubble = 1'b1;
        end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
        end
    end

    assign mem_timeout = timeout_reg && !reset;

`ifdef PIPE_PERF_EN
    logic [31:0] stall_count_reg;
    logic [31:0] flush_count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (!pc_write) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
            if (taken && !pipe_freeze) begin
                flush_count_reg <= flush_count_reg + 32'd1;
            end
        end
    end

    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (main instance plus a WAIT_LIMIT=3 instance).
module tb_pipe_hazard_ctrl;

    localparam int RW = 5;

    // obs = {pipe_freeze, pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, exmem_flush, mem_timeout}
    localparam logic [7:0] O_RST    = 8'h80;
    localparam logic [7:0] O_RUN    = 8'h50;
    localparam logic [7:0] O_LU     = 8'h04;
    localparam logic [7:0] O_TK     = 8'h7E;
    localparam logic [7:0] O_FRZ    = 8'h80;
    localparam logic [7:0] O_FRZ_TO = 8'h81;

    logic          clock;
    logic          reset;
    logic          reset_t;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_uses_rs2;
    logic          ex_mem_read;
    logic [RW-1:0] ex_rd;
    logic          mem_branch;
    logic          mem_uncond;
    logic          mem_zero;
    logic          mem_access;
    logic          dmem_ready;

    logic pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_freeze, mem_timeout;
    logic pc_write_t, pc_src_t, ifid_write_t, ifid_flush_t, idex_bubble_t, exmem_flush_t, pipe_freeze_t, mem_timeout_t;
`ifdef PIPE_PERF_EN
    logic [31:0] stall_count, flush_count, stall_count_t, flush_count_t;
`endif

    logic [7:0] obs;
    logic [7:0] obs_t;
    assign obs   = {pipe_freeze, pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, exmem_flush, mem_timeout};
    assign obs_t = {pipe_freeze_t, pc_write_t, pc_src_t, ifid_write_t, ifid_flush_t, idex_bubble_t,
                    exmem_flush_t, mem_timeout_t};

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(.WAIT_LIMIT(8), .REG_IDX_W(RW)) dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_branch(mem_branch), .mem_uncond(mem_uncond), .mem_zero(mem_zero),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_flush(exmem_flush), .pipe_freeze(pipe_freeze),
        .mem_timeout(mem_timeout)
`ifdef PIPE_PERF_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    pipe_hazard_ctrl #(.WAIT_LIMIT(3), .REG_IDX_W(RW)) dut_t (
        .clock(clock), .reset(reset_t),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_branch(mem_branch), .mem_uncond(mem_uncond), .mem_zero(mem_zero),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_write(pc_write_t), .pc_src(pc_src_t), .ifid_write(ifid_write_t), .ifid_flush(ifid_flush_t),
        .idex_bubble(idex_bubble_t), .exmem_flush(exmem_flush_t), .pipe_freeze(pipe_freeze_t),
        .mem_timeout(mem_timeout_t)
`ifdef PIPE_PERF_EN
        , .stall_count(stall_count_t), .flush_count(flush_count_t)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic idle();
        id_rs1      = '0;
        id_rs2      = '0;
        id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0;
        ex_rd       = '0;
        mem_branch  = 1'b0;
        mem_uncond  = 1'b0;
        mem_zero    = 1'b0;
        mem_access  = 1'b0;
        dmem_ready  = 1'b1;
    endtask

    task automatic load_use_rs1(input logic [RW-1:0] r);
        ex_mem_read = 1'b1;
        ex_rd       = r;
        id_rs1      = r;
    endtask

    initial begin
        reset   = 1'b1;
        reset_t = 1'b1;
        idle();
        repeat (2) @(posedge clock);

        @(negedge clock); #1;
        check_eq("reset_outs", 32'(obs), 32'(O_RST));
        check_eq("reset_outs_t", 32'(obs_t), 32'(O_RST));

        @(negedge clock); reset = 1'b0; #1;
        check_eq("idle_run", 32'(obs), 32'(O_RUN));

        @(negedge clock); idle(); load_use_rs1(5'd3); #1;
        check_eq("load_use_rs1", 32'(obs), 32'(O_LU));
        @(negedge clock); idle(); #1;
        check_eq("load_use_done", 32'(obs), 32'(O_RUN));

        @(negedge clock); idle(); load_use_rs1(5'd31); id_rs2 = 5'd31; id_uses_rs2 = 1'b1; #1;
        check_eq("xzr_no_stall", 32'(obs), 32'(O_RUN));

        @(negedge clock); idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd2; id_rs2 = 5'd7;
        id_uses_rs2 = 1'b1; #1;
        check_eq("load_use_rs2", 32'(obs), 32'(O_LU));
        @(negedge clock); id_uses_rs2 = 1'b0; #1;
        check_eq("rs2_unused", 32'(obs), 32'(O_RUN));

        @(negedge clock); idle(); mem_branch = 1'b1; mem_zero = 1'b1; #1;
        check_eq("cbz_taken", 32'(obs), 32'(O_TK));
        @(negedge clock); idle(); mem_branch = 1'b1; #1;
        check_eq("cbz_not_taken", 32'(obs), 32'(O_RUN));
        @(negedge clock); idle(); mem_branch = 1'b1; mem_uncond = 1'b1; #1;
        check_eq("b_uncond", 32'(obs), 32'(O_TK));

        @(negedge clock); idle(); mem_branch = 1'b1; mem_zero = 1'b1; load_use_rs1(5'd4); #1;
        check_eq("branch_over_load_use", 32'(obs), 32'(O_TK));

        for (int k = 1; k <= 4; k++) begin
            @(negedge clock); idle(); mem_branch = 1'b1; mem_zero = 1'b1; mem_access = 1'b1;
            dmem_ready = 1'b0; #1;
            check_eq($sformatf("freeze_%0d", k), 32'(obs), 32'(O_FRZ));
        end
        @(negedge clock); dmem_ready = 1'b1; #1;
        check_eq("flush_on_ready", 32'(obs), 32'(O_TK));
        @(negedge clock); idle(); #1;
        check_eq("run_after_wait", 32'(obs), 32'(O_RUN));

        @(negedge clock); idle(); mem_access = 1'b1; dmem_ready = 1'b0; #1;
        check_eq("wait_before_reset", 32'(obs), 32'(O_FRZ));
        @(negedge clock); reset = 1'b1; #1;
        check_eq("reset_mid_wait", 32'(obs), 32'(O_RST));
        @(negedge clock); reset = 1'b0; idle(); #1;
        check_eq("run_after_reset", 32'(obs), 32'(O_RUN));

`ifdef PIPE_PERF_EN
        @(negedge clock); idle(); reset = 1'b1;
        @(negedge clock); reset = 1'b0; #1;
        check_eq("stall_count_reset", stall_count, 32'd0);
        check_eq("flush_count_reset", flush_count, 32'd0);
        load_use_rs1(5'd9);
        @(negedge clock); idle();
        @(negedge clock); load_use_rs1(5'd10);
        @(negedge clock); idle();
        @(negedge clock); mem_branch = 1'b1; mem_zero = 1'b1;
        @(negedge clock); idle(); #1;
        check_eq("stall_count", stall_count, 32'd2);
        check_eq("flush_count", flush_count, 32'd1);
`endif

        // WAIT_LIMIT=3 instance: dmem_ready stuck low
        @(negedge clock); idle(); reset_t = 1'b0; mem_access = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clock);
            #1;
            check_eq($sformatf("to_wait_%0d", k), 32'(obs_t), 32'(O_FRZ));
        end
        @(negedge clock); #1;
        check_eq("timeout_set", 32'(obs_t), 32'(O_FRZ_TO));
        @(negedge clock); mem_access = 1'b0; dmem_ready = 1'b1; #1;
        check_eq("halt_held", 32'(obs_t), 32'(O_FRZ_TO));
        @(negedge clock); reset_t = 1'b1; #1;
        check_eq("halt_reset", 32'(obs_t), 32'(O_RST));
        @(negedge clock); reset_t = 1'b0; idle(); #1;
        check_eq("run_after_halt", 32'(obs_t), 32'(O_RUN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
